// File: rtl/tile_map_pkg.sv
// Shared constants, types and FSM encoding for the tile-map controller.
package tile_map_pkg;

  localparam int unsigned COLS      = 20;
  localparam int unsigned ROWS      = 15;
  localparam int unsigned TILE_PX   = 32;
  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned MAP_DEPTH = COLS * ROWS;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned TILE_W    = 4;

  typedef logic [TILE_W-1:0] tile_t;

  typedef enum logic [0:0] {
    StFill,
    StIdle
  } state_e;

endpackage

// File: rtl/tile_map_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] idx;
  logic            found;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    if (enable) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        idx = PtrW'((32'(ptr_q) + i) % NUM_REQ);
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          ptr_d    = PtrW'((32'(idx) + 1) % NUM_REQ);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/tile_map_ctrl.sv
// Tile-ID map: 1-cycle VGA read port, arbitrated requester writes, whole-map fills.
// Optional drop counter for out-of-range writes enabled by TILE_MAP_DROP_CNT_EN.
module tile_map_ctrl
  import tile_map_pkg::*;
#(
  parameter int unsigned COLS       = 20,
  parameter int unsigned ROWS       = 15,
  parameter int unsigned TILE_W     = 4,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned RESET_FILL = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [9:0]                h_cnt,
  input  logic [9:0]                v_cnt,
  output logic [TILE_W-1:0]         tile_id,
  output logic                      tile_valid,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*5-1:0]      req_col,
  input  logic [NUM_REQ*4-1:0]      req_row,
  input  logic [NUM_REQ*TILE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      fill_start,
  input  logic [TILE_W-1:0]         fill_value,
  output logic                      busy
`ifdef TILE_MAP_DROP_CNT_EN
  ,
  output logic [7:0]                drop_cnt
`endif
);

  localparam int unsigned Depth = COLS * ROWS;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
  logic [TILE_W-1:0]   fill_val_q, fill_val_d;
  logic [TILE_W-1:0]   mem_q [Depth];

  logic                fill_go, arb_en;
  logic [4:0]          wr_col;
  logic [3:0]          wr_row;
  logic [TILE_W-1:0]   wr_data;
  logic                wr_in_range;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [TILE_W-1:0]   mem_wdata;
  logic                rd_active;
  logic [ADDR_W-1:0]   rd_addr;
  logic [TILE_W-1:0]   tile_id_q;
  logic                tile_valid_q;

  assign fill_go = (state_q == StIdle) && fill_start;
  assign arb_en  = (state_q == StIdle) && !fill_start;
  assign busy    = (state_q == StFill);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .enable (arb_en),
    .gnt    (gnt)
  );

  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    fill_val_d  = fill_val_q;
    unique case (state_q)
      StFill: begin
        fill_addr_d = fill_addr_q + 1'b1;
        if (fill_addr_q == ADDR_W'(Depth - 1)) begin
          state_d     = StIdle;
          fill_addr_d = '0;
        end
      end
      StIdle: begin
        if (fill_start) begin
          state_d     = StFill;
          fill_val_d  = fill_value;
          fill_addr_d = '0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFill;
      fill_addr_q <= '0;
      fill_val_q  <= TILE_W'(RESET_FILL);
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      fill_val_q  <= fill_val_d;
    end
  end

  // Mux out the granted requester's write fields.
  always_comb begin
    wr_col  = '0;
    wr_row  = '0;
    wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        wr_col  = req_col[i*5 +: 5];
        wr_row  = req_row[i*4 +: 4];
        wr_data = req_data[i*TILE_W +: TILE_W];
      end
    end
  end

  assign wr_in_range = (wr_col < 5'(COLS)) && (wr_row < 4'(ROWS));
  assign mem_we      = !rst && ((state_q == StFill) || ((|gnt) && wr_in_range));
  assign mem_waddr   = (state_q == StFill) ? fill_addr_q
                                           : ADDR_W'(32'(wr_row) * COLS + 32'(wr_col));
  assign mem_wdata   = (state_q == StFill) ? fill_val_q : wr_data;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read samples pre-write contents, so a same-cycle write returns old data.
  assign rd_active = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
  assign rd_addr   = ADDR_W'(32'(v_cnt[9:5]) * COLS + 32'(h_cnt[9:5]));

  always_ff @(posedge clk) begin
    if (rst) begin
      tile_id_q    <= '0;
      tile_valid_q <= 1'b0;
    end else begin
      tile_valid_q <= rd_active;
      tile_id_q    <= rd_active ? mem_q[rd_addr] : '0;
    end
  end

  assign tile_id    = tile_id_q;
  assign tile_valid = tile_valid_q;

`ifdef TILE_MAP_DROP_CNT_EN
  logic [7:0] drop_cnt_q;
  logic       req_drop;

  assign req_drop = (|gnt) && !wr_in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (fill_go) begin
      drop_cnt_q <= '0;
    end else if (req_drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
